lane_unrotator: RTL

LANE_UNROTATOR -- requirements
Module: lane_unrotator

---
 rtl/lane_unrotator.sv | 118 +++++++++++
 1 files changed

// File: rtl/lane_unrotator.sv
// lane_unrotator
//   Undoes a left rotation of N_LANES lanes. A running head pointer records
//   how many lanes earlier beats used. Each accepted beat is right-rotated by
//   the head value that was current before that beat arrived. The head then
//   advances by the number of lanes the beat used.
//
// Ports
//   clk, rst_n : clock; asynchronous active-low reset.
//   flush_i    : synchronous clear of head and output register; drops the input beat.
//   valid_i    : upstream handshake.
//   ready_o    : upstream handshake.
//   data_i     : rotated lanes; lane k at [k*LW +: LW].
//   cnt_i      : lanes consumed by this beat; values above N_LANES clamp to N_LANES.
//   valid_o    : downstream handshake.
//   ready_i    : downstream handshake.
//   data_o     : un-rotated lanes.
//   head_o     : registered head pointer.
//
// Handshake: a beat moves on a rising edge when valid and ready are both 1 on
// that side. valid_o/data_o are held stable until ready_i accepts them.
// ready_o depends combinationally on ready_i, so a beat can be accepted in the
// same cycle the previous beat is handed off.
module lane_unrotator #(
  parameter int N_LANES = 4,
  parameter int LW      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [N_LANES*LW-1:0]        data_i,
  input  logic [$clog2(N_LANES+1)-1:0] cnt_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [N_LANES*LW-1:0]        data_o,
  output logic [$clog2(N_LANES)-1:0]   head_o
);

  localparam int HW = $clog2(N_LANES);
  localparam int CW = $clog2(N_LANES+1);
  localparam int DW = N_LANES*LW;

  logic [HW-1:0] head_q, head_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  logic          accept;
  logic          handoff;
  logic [HW-1:0] cnt_step;
  logic [DW-1:0] rot_data;

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o && !flush_i;
  assign handoff = valid_q && ready_i;

  // A count of N_LANES (or a count clamped to N_LANES) is a full turn.
  // The head therefore does not move, so the step is 0.
  assign cnt_step = (cnt_i >= CW'(N_LANES)) ? '0 : cnt_i[HW-1:0];

  // Right rotation by head_q, one stage per head bit.
  // Stage s rotates right by 2**s lanes when head_q[s] is set.
  for (genvar s = 0; s < HW; s++) begin : g_stage
    localparam int SH = 1 << s;
    logic [DW-1:0] in_s;
    logic [DW-1:0] rot_s;
    logic [DW-1:0] out_s;

    if (s == 0) begin : g_first
      assign in_s = data_i;
    end else begin : g_chain
      assign in_s = g_stage[s-1].out_s;
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      assign rot_s[k*LW +: LW] = in_s[((k + SH) % N_LANES)*LW +: LW];
    end

    assign out_s = head_q[s] ? rot_s : in_s;
  end

  assign rot_data = g_stage[HW-1].out_s;

  always_comb begin
    head_d  = head_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      head_d  = '0;
      valid_d = 1'b0;
      data_d  = '0;
    end else if (accept) begin
      // The rotation uses the old head; the head advances on this same edge.
      head_d  = head_q + cnt_step;
      valid_d = 1'b1;
      data_d  = rot_data;
    end else if (handoff) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign head_o  = head_q;

endmodule
